bus_mux_switch_n: RTL and testbench

//   Parametrised N-source register-bus selector; successor to the fixed 4x8 two-bit-select mux switch.

---
 rtl/bus_mux_switch_n.sv | 118 +++++++++++
 tb/tb_bus_mux_switch_n.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_switch_n.sv
// N-source register-bus selector with a registered valid/ready output stage.
// Sources are chosen by a loaded manual index or by a round-robin scan with a fixed dwell per source.
module bus_mux_switch_n #(
    parameter int DATA_W     = 8,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 2,
    parameter int SCAN_DWELL = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [NUM_SRC*DATA_W-1:0]   in_data,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        sel_load,
    input  logic                        mode,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           output_x,
    output logic [SEL_W-1:0]            cur_sel,
    output logic                        sel_err,
    output logic                        scan_wrap
);

    localparam int DWELL_W = $clog2(SCAN_DWELL + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_SRC - 1);

    typedef enum logic {
        S_MAN,
        S_SCAN
    } state_t;

    state_t               state_q;
    logic [SEL_W-1:0]     curSel_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DATA_W-1:0]    outputX_q;
    logic                 outValid_q;
    logic                 selErr_q;
    logic                 scanWrap_q;

    logic                 cap;
    logic                 selInRange;
    logic                 dwellDone;
    logic [DATA_W-1:0]    srcData_d;
    logic [SEL_W-1:0]     nextSel_d;

    // The output stage accepts new data whenever it is empty or the consumer is taking the current word.
    assign cap        = !outValid_q || out_ready;
    assign selInRange = ({1'b0, sel} < (SEL_W + 1)'(NUM_SRC));
    assign dwellDone  = (dwell_q == DWELL_LAST);
    assign nextSel_d  = (curSel_q == SEL_LAST) ? '0 : curSel_q + SEL_W'(1);

    always_comb begin
        srcData_d = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (curSel_q == SEL_W'(k)) begin
                srcData_d = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Capture always uses the pre-edge cur_sel, so an index change shows up on output_x one edge later.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_MAN;
            curSel_q   <= '0;
            dwell_q    <= '0;
            outputX_q  <= '0;
            outValid_q <= 1'b0;
            selErr_q   <= 1'b0;
            scanWrap_q <= 1'b0;
        end else begin
            selErr_q   <= 1'b0;
            scanWrap_q <= 1'b0;
            if (cap) begin
                outputX_q  <= srcData_d;
                outValid_q <= 1'b1;
            end
            case (state_q)
                S_MAN: begin
                    if (sel_load) begin
                        if (selInRange) begin
                            curSel_q <= sel;
                        end else begin
                            selErr_q <= 1'b1;
                        end
                    end
                    if (mode) begin
                        state_q <= S_SCAN;
                        dwell_q <= '0;
                    end
                end
                S_SCAN: begin
                    // Dwell counts accepted transfers only; a stalled consumer freezes the scan.
                    if (cap) begin
                        if (dwellDone) begin
                            dwell_q    <= '0;
                            curSel_q   <= nextSel_d;
                            scanWrap_q <= (curSel_q == SEL_LAST);
                        end else begin
                            dwell_q <= dwell_q + DWELL_W'(1);
                        end
                    end
                    if (!mode) begin
                        state_q <= S_MAN;
                    end
                end
                default: state_q <= S_MAN;
            endcase
        end
    end

    assign out_valid = outValid_q;
    assign output_x  = outputX_q;
    assign cur_sel   = curSel_q;
    assign sel_err   = selErr_q;
    assign scan_wrap = scanWrap_q;

endmodule

// File: tb/tb_bus_mux_switch_n.sv
// Bench for bus_mux_switch_n: a 4-source/dwell-2 and a 3-source/dwell-1 instance share stimulus,
// checked against fixed vectors, hand sequences and a behavioural model under random traffic.
module tb_bus_mux_switch_n;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  sel;
    logic        sel_load;
    logic        mode;
    logic        out_ready;
    logic [31:0] inData;
    logic [23:0] inDataB;

    logic        validA, errA, wrapA;
    logic [7:0]  outA;
    logic [1:0]  curSelA;
    logic        validB, errB, wrapB;
    logic [7:0]  outB;
    logic [1:0]  curSelB;

    int checks = 0;
    int errors = 0;

    assign inDataB = inData[23:0];

    always #5 sys_clk = ~sys_clk;

    bus_mux_switch_n #(.DATA_W(8), .NUM_SRC(4), .SEL_W(2), .SCAN_DWELL(2)) dutA (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(inData), .sel(sel), .sel_load(sel_load),
        .mode(mode), .out_ready(out_ready), .out_valid(validA), .output_x(outA),
        .cur_sel(curSelA), .sel_err(errA), .scan_wrap(wrapA)
    );

    bus_mux_switch_n #(.DATA_W(8), .NUM_SRC(3), .SEL_W(2), .SCAN_DWELL(1)) dutB (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(inDataB), .sel(sel), .sel_load(sel_load),
        .mode(mode), .out_ready(out_ready), .out_valid(validB), .output_x(outB),
        .cur_sel(curSelB), .sel_err(errB), .scan_wrap(wrapB)
    );

    typedef struct {
        bit scan;
        int sel;
        int dwell;
        int outx;
        bit valid;
        bit err;
        bit wrap;
    } model_t;

    typedef struct {
        bit rst;
        int s;
        bit ld;
        bit md;
        bit rdy;
        int expOut;
        bit expValid;
        int expSel;
        bit expErr;
        bit expWrap;
    } vec_t;

    model_t mA, mB;

    function automatic model_t modelReset();
        model_t m;
        m.scan = 1'b0; m.sel = 0; m.dwell = 0; m.outx = 0;
        m.valid = 1'b0; m.err = 1'b0; m.wrap = 1'b0;
        return m;
    endfunction

    // One clock edge of the selector, described from the behavioural rules.
    function automatic model_t modelStep(model_t m, int nsrc, int dwellN, logic [31:0] data,
                                         bit rst, int selIn, bit load, bit modeIn, bit rdy);
        model_t n;
        bit accept;
        if (rst) return modelReset();
        n = m;
        n.err = 1'b0;
        n.wrap = 1'b0;
        accept = !m.valid || rdy;
        if (accept) begin
            n.outx = int'((data >> (8 * m.sel)) & 32'hff);
            n.valid = 1'b1;
        end
        if (!m.scan) begin
            if (load) begin
                if (selIn < nsrc) n.sel = selIn;
                else n.err = 1'b1;
            end
            if (modeIn) begin
                n.scan = 1'b1;
                n.dwell = 0;
            end
        end else begin
            if (accept) begin
                if (m.dwell + 1 >= dwellN) begin
                    n.dwell = 0;
                    n.sel = (m.sel + 1) % nsrc;
                    n.wrap = (n.sel == 0);
                end else begin
                    n.dwell = m.dwell + 1;
                end
            end
            if (!modeIn) n.scan = 1'b0;
        end
        return n;
    endfunction

    function automatic vec_t vec(bit rst, int s, bit ld, bit md, bit rdy,
                                 int eo, bit ev, int es, bit ee, bit ew);
        vec_t v;
        v.rst = rst; v.s = s; v.ld = ld; v.md = md; v.rdy = rdy;
        v.expOut = eo; v.expValid = ev; v.expSel = es; v.expErr = ee; v.expWrap = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input int s, input bit ld, input bit md, input bit rdy);
        sys_rst = rst;
        sel = 2'(s);
        sel_load = ld;
        mode = md;
        out_ready = rdy;
        @(posedge sys_clk);
        mA = modelStep(mA, 4, 2, inData, rst, s, ld, md, rdy);
        mB = modelStep(mB, 3, 1, {8'h00, inData[23:0]}, rst, s, ld, md, rdy);
        @(negedge sys_clk);
    endtask

    task automatic checkOutput();
        check("A.out_valid", validA, mA.valid);
        check("A.output_x", outA, mA.outx);
        check("A.cur_sel", curSelA, mA.sel);
        check("A.sel_err", errA, mA.err);
        check("A.scan_wrap", wrapA, mA.wrap);
        check("B.out_valid", validB, mB.valid);
        check("B.output_x", outB, mB.outx);
        check("B.cur_sel", curSelB, mB.sel);
        check("B.sel_err", errB, mB.err);
        check("B.scan_wrap", wrapB, mB.wrap);
    endtask

    initial begin
        vec_t vecs[18];
        model_t snap;
        bit rMode;

        sys_rst = 1'b1; sel = '0; sel_load = 1'b0; mode = 1'b0; out_ready = 1'b1;
        inData = 32'h13121110;
        mA = modelReset();
        mB = modelReset();

        // Expectations for the 4-source, dwell-2 instance after each edge.
        vecs[0]  = vec(1'b1, 0, 1'b0, 1'b0, 1'b1, 'h00, 1'b0, 0, 1'b0, 1'b0);
        vecs[1]  = vec(1'b1, 0, 1'b0, 1'b0, 1'b1, 'h00, 1'b0, 0, 1'b0, 1'b0);
        vecs[2]  = vec(1'b0, 0, 1'b0, 1'b0, 1'b1, 'h10, 1'b1, 0, 1'b0, 1'b0);
        vecs[3]  = vec(1'b0, 2, 1'b1, 1'b0, 1'b1, 'h10, 1'b1, 2, 1'b0, 1'b0);
        vecs[4]  = vec(1'b0, 2, 1'b0, 1'b0, 1'b1, 'h12, 1'b1, 2, 1'b0, 1'b0);
        vecs[5]  = vec(1'b0, 3, 1'b1, 1'b0, 1'b1, 'h12, 1'b1, 3, 1'b0, 1'b0);
        vecs[6]  = vec(1'b0, 3, 1'b0, 1'b0, 1'b1, 'h13, 1'b1, 3, 1'b0, 1'b0);
        vecs[7]  = vec(1'b0, 0, 1'b1, 1'b0, 1'b1, 'h13, 1'b1, 0, 1'b0, 1'b0);
        vecs[8]  = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h10, 1'b1, 0, 1'b0, 1'b0);
        vecs[9]  = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h10, 1'b1, 0, 1'b0, 1'b0);
        vecs[10] = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h10, 1'b1, 1, 1'b0, 1'b0);
        vecs[11] = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h11, 1'b1, 1, 1'b0, 1'b0);
        vecs[12] = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h11, 1'b1, 2, 1'b0, 1'b0);
        vecs[13] = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h12, 1'b1, 2, 1'b0, 1'b0);
        vecs[14] = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h12, 1'b1, 3, 1'b0, 1'b0);
        vecs[15] = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h13, 1'b1, 3, 1'b0, 1'b0);
        vecs[16] = vec(1'b0, 0, 1'b0, 1'b1, 1'b1, 'h13, 1'b1, 0, 1'b0, 1'b1);
        vecs[17] = vec(1'b0, 2, 1'b1, 1'b1, 1'b1, 'h10, 1'b1, 0, 1'b0, 1'b0);

        @(negedge sys_clk);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].s, vecs[i].ld, vecs[i].md, vecs[i].rdy);
            check($sformatf("vec%0d.output_x", i), outA, vecs[i].expOut);
            check($sformatf("vec%0d.out_valid", i), validA, vecs[i].expValid);
            check($sformatf("vec%0d.cur_sel", i), curSelA, vecs[i].expSel);
            check($sformatf("vec%0d.sel_err", i), errA, vecs[i].expErr);
            check($sformatf("vec%0d.scan_wrap", i), wrapA, vecs[i].expWrap);
            checkOutput();
        end

        // Consumer stall in scan mode: everything must hold, then the sequence resumes.
        snap = mA;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
            check("stall.output_x", outA, snap.outx);
            check("stall.out_valid", validA, 1);
            check("stall.cur_sel", curSelA, snap.sel);
            checkOutput();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
            checkOutput();
        end

        // Reset in the middle of a stalled scan.
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, 1'b1, 1'b0);
        check("midrst.output_x", outA, 'h00);
        check("midrst.out_valid", validA, 0);
        check("midrst.cur_sel", curSelA, 0);
        checkOutput();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("postrst.output_x", outA, 'h10);
        check("postrst.out_valid", validA, 1);
        checkOutput();

        // Out-of-range load on the 3-source instance.
        applyStimulus(1'b0, 1, 1'b1, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 3, 1'b1, 1'b0, 1'b1);
        check("badsel.sel_err", errB, 1);
        check("badsel.cur_sel", curSelB, 1);
        check("badsel.output_x", outB, 'h11);
        checkOutput();
        applyStimulus(1'b0, 3, 1'b0, 1'b0, 1'b1);
        check("badsel.err_clear", errB, 0);
        check("badsel.cur_sel_hold", curSelB, 1);
        check("badsel.output_x_hold", outB, 'h11);
        checkOutput();

        rMode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            inData = $urandom;
            if ($urandom_range(0, 9) == 0) rMode = !rMode;
            applyStimulus($urandom_range(0, 99) < 3, int'($urandom_range(0, 3)),
                          $urandom_range(0, 9) < 3, rMode, $urandom_range(0, 9) < 6);
            checkOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
